// File: rtl/rhd_batch_framer.sv
// Frames the synchronised RHD channel-word stream into AXI4-Stream DMA packets:
// each frame is a 64-bit magic header plus NUM_CH channel words, packet_len frames per packet.
module rhd_batch_framer #(
    parameter int          NUM_CH = 32,
    parameter logic [63:0] MAGIC  = 64'hC691_1999_2702_1942,
    parameter int          LEN_W  = 8
) (
    input  logic             clk_dma,
    input  logic             rstn_dma,
    input  logic             enable,
    input  logic [LEN_W-1:0] packet_len,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             busy,
    output logic [31:0]      pkt_cnt,
    output logic [15:0]      err_cnt
);

    localparam int WC_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam logic [WC_W-1:0] LAST_WC = WC_W'(NUM_CH - 1);

    localparam logic [2:0] S_WAIT_SOF = 3'd0;
    localparam logic [2:0] S_MAGIC_LO = 3'd1;
    localparam logic [2:0] S_MAGIC_HI = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_PAD      = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
    logic [LEN_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      pkt_cnt_q, pkt_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [31:0]      tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;

    logic             adv;
    logic             load;
    logic [31:0]      ld_data;
    logic             ld_last;
    logic             frame_end;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign adv = !tvalid_q || m_axis_tready;

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        len_d         = len_q;
        pkt_cnt_d     = pkt_cnt_q;
        err_cnt_d     = err_cnt_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        s_axis_tready = 1'b0;
        load          = 1'b0;
        ld_data       = 32'h0;
        ld_last       = 1'b0;
        frame_end     = 1'b0;

        case (state_q)
            S_WAIT_SOF: begin
                if (enable && s_axis_tvalid) begin
                    if (!s_axis_tuser) begin
                        s_axis_tready = 1'b1;
                        err_cnt_d     = sat_inc16(err_cnt_q);
                    end else begin
                        // Packet length is only sampled at the first frame of a packet.
                        if (frame_cnt_q == '0)
                            len_d = (packet_len == '0) ? LEN_W'(1) : packet_len;
                        state_d = S_MAGIC_LO;
                    end
                end
            end
            S_MAGIC_LO: begin
                if (adv) begin
                    load    = 1'b1;
                    ld_data = MAGIC[31:0];
                    state_d = S_MAGIC_HI;
                end
            end
            S_MAGIC_HI: begin
                if (adv) begin
                    load       = 1'b1;
                    ld_data    = MAGIC[63:32];
                    word_cnt_d = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (s_axis_tvalid && s_axis_tuser && (word_cnt_q != '0)) begin
                    // Early SOF: leave the SOF word waiting, pad out the broken frame.
                    if (adv) begin
                        err_cnt_d = sat_inc16(err_cnt_q);
                        state_d   = S_PAD;
                    end
                end else begin
                    s_axis_tready = adv;
                    if (adv && s_axis_tvalid) begin
                        load       = 1'b1;
                        ld_data    = s_axis_tdata;
                        word_cnt_d = word_cnt_q + WC_W'(1);
                        frame_end  = (word_cnt_q == LAST_WC);
                    end
                end
            end
            S_PAD: begin
                if (adv) begin
                    load       = 1'b1;
                    ld_data    = 32'h0;
                    word_cnt_d = word_cnt_q + WC_W'(1);
                    frame_end  = (word_cnt_q == LAST_WC);
                end
            end
            default: state_d = S_WAIT_SOF;
        endcase

        if (frame_end) begin
            state_d    = S_WAIT_SOF;
            word_cnt_d = '0;
            if (frame_cnt_q == len_q - LEN_W'(1)) begin
                ld_last     = 1'b1;
                frame_cnt_d = '0;
                pkt_cnt_d   = pkt_cnt_q + 32'd1;
            end else begin
                frame_cnt_d = frame_cnt_q + LEN_W'(1);
            end
        end

        // Single output stage: only moves when empty or being drained.
        if (adv) begin
            if (load) begin
                tdata_d  = ld_data;
                tvalid_d = 1'b1;
                tlast_d  = ld_last;
            end else begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_dma or negedge rstn_dma) begin
        if (!rstn_dma) begin
            state_q     <= S_WAIT_SOF;
            word_cnt_q  <= '0;
            frame_cnt_q <= '0;
            len_q       <= LEN_W'(1);
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            len_q       <= len_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign busy          = (state_q != S_WAIT_SOF) || tvalid_q;

endmodule

// File: tb/tb_rhd_batch_framer.sv
// Randomised bench for rhd_batch_framer: input beats are turned into the expected
// packet stream by a frame-level model and compared word by word at the output.
module tb_rhd_batch_framer;

    localparam int          NUM_CH = 32;
    localparam logic [63:0] MAGIC  = 64'hC691_1999_2702_1942;
    localparam int          LEN_W  = 8;

    logic             clk_dma = 1'b0;
    logic             rstn_dma;
    logic             enable;
    logic [LEN_W-1:0] packet_len;
    logic [31:0]      s_axis_tdata;
    logic             s_axis_tuser;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [31:0]      m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic             busy;
    logic [31:0]      pkt_cnt;
    logic [15:0]      err_cnt;

    rhd_batch_framer #(.NUM_CH(NUM_CH), .MAGIC(MAGIC), .LEN_W(LEN_W)) dut (
        .clk_dma(clk_dma), .rstn_dma(rstn_dma), .enable(enable), .packet_len(packet_len),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk_dma = ~clk_dma;

    int total = 0;
    int bad   = 0;

    logic [32:0] in_q[$];   // {tuser, data}
    logic [32:0] exp_q[$];  // {tlast, data}
    logic [32:0] obs_q[$];
    int          in_idx;
    int          exp_tot;
    int          m_err, m_pkt;
    int          v_pct, r_pct;
    bit          bp_chk;
    bit          en_drv;
    bit          prev_stall;
    logic [32:0] prev_word;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: walks the input beats and writes out the packet words.
    task automatic build_model(input int len);
        int L, pos, frames, i;
        bit in_frame;
        logic [32:0] t;
        L = (len == 0) ? 1 : len;
        pos = 0; frames = 0; i = 0; in_frame = 0;
        exp_q.delete(); m_err = 0; m_pkt = 0;
        while (i < in_q.size()) begin
            if (in_frame && in_q[i][32] && pos != 0) begin
                m_err++;
                while (pos < NUM_CH) begin exp_q.push_back(33'd0); pos++; end
            end else if (!in_frame && !in_q[i][32]) begin
                m_err++;
                i++;
                continue;
            end else begin
                if (!in_frame) begin
                    exp_q.push_back({1'b0, MAGIC[31:0]});
                    exp_q.push_back({1'b0, MAGIC[63:32]});
                    in_frame = 1; pos = 0;
                end
                exp_q.push_back({1'b0, in_q[i][31:0]});
                pos++; i++;
            end
            if (pos == NUM_CH) begin
                if (frames == L - 1) begin
                    t = exp_q.pop_back(); t[32] = 1'b1; exp_q.push_back(t);
                    frames = 0; m_pkt++;
                end else begin
                    frames++;
                end
                in_frame = 0; pos = 0;
            end
        end
        exp_tot = exp_q.size();
    endtask

    task automatic add_frame(input int n, input bit idx_data);
        for (int c = 0; c < n; c++)
            in_q.push_back({(c == 0), idx_data ? 32'(c) : 32'($urandom)});
    endtask

    task automatic cycle();
        bit s_hs;
        @(negedge clk_dma);
        if (prev_stall) begin
            check("hold_vld", 64'(m_axis_tvalid), 64'd1);
            check("hold_word", 64'({m_axis_tlast, m_axis_tdata}), 64'(prev_word));
        end
        if (bp_chk && m_axis_tvalid && !m_axis_tready)
            check("stall_s_ready", 64'(s_axis_tready), 64'd0);
        if (m_axis_tvalid && m_axis_tready) begin
            obs_q.push_back({m_axis_tlast, m_axis_tdata});
            if (exp_q.size() == 0) check("word_count", 64'(obs_q.size()), 64'(exp_tot));
            else check("word", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q.pop_front()));
        end
        s_hs = s_axis_tvalid && s_axis_tready;
        if (s_hs) in_idx++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_word  = {m_axis_tlast, m_axis_tdata};
        @(posedge clk_dma);
        #1;
        if (!(s_axis_tvalid && !s_hs)) begin
            if (in_idx < in_q.size() && $urandom_range(99) < v_pct) begin
                s_axis_tvalid = 1'b1;
                {s_axis_tuser, s_axis_tdata} = in_q[in_idx];
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tuser  = 1'b0;
                s_axis_tdata  = $urandom;
            end
        end
        m_axis_tready = ($urandom_range(99) < r_pct);
        enable = en_drv;
    endtask

    task automatic do_reset(input bit chk);
        rstn_dma = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tdata = '0;
        m_axis_tready = 1'b0; enable = 1'b0; prev_stall = 0; bp_chk = 0;
        in_q.delete(); obs_q.delete(); exp_q.delete(); in_idx = 0;
        repeat (2) @(posedge clk_dma);
        #1;
        if (chk) begin
            check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
            check("rst_tlast", 64'(m_axis_tlast), 64'd0);
            check("rst_tdata", 64'(m_axis_tdata), 64'd0);
            check("rst_s_ready", 64'(s_axis_tready), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_pkt", 64'(pkt_cnt), 64'd0);
            check("rst_err", 64'(err_cnt), 64'd0);
        end
        @(negedge clk_dma);
        rstn_dma = 1'b1;
        @(posedge clk_dma);
        #1;
        en_drv = 1'b1; enable = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (!(in_idx == in_q.size() && exp_q.size() == 0 && !m_axis_tvalid) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_pending_out"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_pending_in"}, 64'(in_idx), 64'(in_q.size()));
        check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(m_pkt));
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'(m_err));
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lasts, n;
        packet_len = 8'd2;
        v_pct = 100; r_pct = 100;
        do_reset(1);

        // Nominal: two frames of channel-index data, len=2, no backpressure.
        add_frame(NUM_CH, 1); add_frame(NUM_CH, 1);
        build_model(2);
        drain("nom", 2000);
        check("nom_words", 64'(obs_q.size()), 64'd68);
        if (obs_q.size() == 68) begin
            check("nom_w0", 64'(obs_q[0]), 64'h0_2702_1942);
            check("nom_w1", 64'(obs_q[1]), 64'h0_C691_1999);
            check("nom_w2", 64'(obs_q[2]), 64'h0);
            check("nom_w33", 64'(obs_q[33]), 64'd31);
            check("nom_w34", 64'(obs_q[34]), 64'h0_2702_1942);
            check("nom_w67", 64'(obs_q[67]), {31'd0, 1'b1, 32'd31});
        end
        lasts = 0;
        foreach (obs_q[k]) if (obs_q[k][32]) lasts++;
        check("nom_tlasts", 64'(lasts), 64'd1);

        // packet_len=0: every frame is a packet.
        do_reset(0);
        packet_len = 8'd0; v_pct = 70; r_pct = 70;
        for (int f = 0; f < 3; f++) add_frame(NUM_CH, 0);
        build_model(0);
        drain("len0", 3000);

        // Random 50% backpressure over three len=1 packets.
        do_reset(0);
        packet_len = 8'd1; v_pct = 80; r_pct = 50; bp_chk = 1;
        for (int f = 0; f < 3; f++) add_frame(NUM_CH, 0);
        build_model(1);
        drain("bp", 4000);
        bp_chk = 0;

        // Early SOF after 10 words.
        do_reset(0);
        v_pct = 90; r_pct = 80;
        add_frame(10, 0); add_frame(NUM_CH, 0);
        build_model(1);
        drain("esof", 3000);
        if (obs_q.size() > 36) begin
            check("esof_pad", 64'(obs_q[33][31:0]), 64'd0);
            check("esof_magic", 64'(obs_q[34][31:0]), 64'h2702_1942);
            check("esof_ch0", 64'(obs_q[36][31:0]), 64'(in_q[10][31:0]));
        end

        // Orphan words ahead of the first SOF.
        do_reset(0);
        for (int k = 0; k < 5; k++) in_q.push_back({1'b0, 32'($urandom)});
        add_frame(NUM_CH, 0);
        build_model(1);
        drain("orph", 2000);
        if (obs_q.size() > 0) check("orph_first", 64'(obs_q[0][31:0]), 64'h2702_1942);

        // Enable dropped after frame 1 of a len=3 packet.
        do_reset(0);
        packet_len = 8'd3; v_pct = 90; r_pct = 70;
        for (int f = 0; f < 3; f++) add_frame(NUM_CH, 0);
        build_model(3);
        n = 0;
        while (in_idx < NUM_CH && n < 1000) begin cycle(); n++; end
        check("en_frame1_in", 64'(in_idx), 64'(NUM_CH));
        en_drv = 1'b0; enable = 1'b0; r_pct = 0;
        repeat (20) cycle();
        check("en_stall_in", 64'(in_idx), 64'(NUM_CH));
        check("en_stall_busy", 64'(busy), 64'd1);
        check("en_stall_pkt", 64'(pkt_cnt), 64'd0);
        en_drv = 1'b1; r_pct = 60;
        drain("en", 4000);
        lasts = 0;
        foreach (obs_q[k]) if (obs_q[k][32]) lasts++;
        check("en_tlasts", 64'(lasts), 64'd1);

        // Asynchronous reset in the middle of a frame.
        do_reset(0);
        packet_len = 8'd1; v_pct = 100; r_pct = 100;
        in_q.push_back({1'b0, 32'h1}); in_q.push_back({1'b0, 32'h2});
        add_frame(NUM_CH, 0); add_frame(NUM_CH, 0);
        build_model(1);
        n = 0;
        while (in_idx < 2 + NUM_CH + 10 && n < 1000) begin cycle(); n++; end
        check("mid_pkt_before", 64'(pkt_cnt), 64'd1);
        check("mid_err_before", 64'(err_cnt), 64'd2);
        #2 rstn_dma = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_pkt", 64'(pkt_cnt), 64'd0);
        check("mid_rst_err", 64'(err_cnt), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        do_reset(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
